nios2_mul_pipe: RTL and testbench

NIOS2_MUL_PIPE -- requirements
Module: nios2_mul_pipe

---
 rtl/nios2_mul_pipe.sv | 129 ++++++++++++
 tb/tb_nios2_mul_pipe.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_mul_pipe.sv
// nios2_mul_pipe: three-stage pipelined multiplier for MUL/MULXUU/MULXSU/MULXSS.
// Split-half unsigned partial products, unsigned sum, then a signed fix-up on the high half.
module nios2_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int H  = DATA_W / 2;
  localparam int PW = 2 * DATA_W;

  generate
    if ((DATA_W % 2) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_w
      $error("nios2_mul_pipe: DATA_W must be even and within 8..64");
    end
  endgenerate

  logic adv;
  logic take;
  logic s1_v, s2_v, s3_v;

  logic [H-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic neg1, neg2;

  logic [DATA_W-1:0] s1_ll, s1_lh, s1_hl, s1_hh;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [1:0]        s1_mode;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_neg1, s1_neg2;

  logic [PW-1:0]     s2_p;
  logic [DATA_W-1:0] s2_a, s2_b;
  logic [1:0]        s2_mode;
  logic [TAG_W-1:0]  s2_tag;
  logic              s2_neg1, s2_neg2;

  logic [DATA_W-1:0] hi_fix;

  // the whole pipe moves together; a stalled output freezes every stage
  assign adv       = ~s3_v | out_ready;
  assign in_ready  = adv & ~flush & reset_n;
  assign take      = in_valid & in_ready;
  assign out_valid = s3_v;

  assign a_lo = in_src1[H-1:0];
  assign a_hi = in_src1[DATA_W-1:H];
  assign b_lo = in_src2[H-1:0];
  assign b_hi = in_src2[DATA_W-1:H];

  assign pp_ll = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
  assign pp_lh = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_hi};
  assign pp_hl = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_lo};
  assign pp_hh = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_hi};

  // src1 is signed for MULXSU/MULXSS, src2 only for MULXSS
  assign neg1 = in_mode[1] & in_src1[DATA_W-1];
  assign neg2 = (&in_mode) & in_src2[DATA_W-1];

  // a negative signed operand weighs -2^DATA_W more than its unsigned
  // reading, so only the high half needs the other operand subtracted
  assign hi_fix = s2_p[PW-1:DATA_W]
                - (s2_neg1 ? s2_b : '0)
                - (s2_neg2 ? s2_a : '0);

  // stage valid bits: cleared by reset or flush, shifted on advance
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else if (adv) begin
      s1_v <= take;
      s2_v <= s1_v;
      s3_v <= s2_v;
    end
  end

  // S1/S2 data: loaded on advance, no reset needed
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_ll   <= pp_ll;
      s1_lh   <= pp_lh;
      s1_hl   <= pp_hl;
      s1_hh   <= pp_hh;
      s1_a    <= in_src1;
      s1_b    <= in_src2;
      s1_mode <= in_mode;
      s1_tag  <= in_tag;
      s1_neg1 <= neg1;
      s1_neg2 <= neg2;
      s2_p    <= {{DATA_W{1'b0}}, s1_ll}
               + {{H{1'b0}}, s1_lh, {H{1'b0}}}
               + {{H{1'b0}}, s1_hl, {H{1'b0}}}
               + {s1_hh, {DATA_W{1'b0}}};
      s2_a    <= s1_a;
      s2_b    <= s1_b;
      s2_mode <= s1_mode;
      s2_tag  <= s1_tag;
      s2_neg1 <= s1_neg1;
      s2_neg2 <= s1_neg2;
    end
  end

  // S3 output registers: half select, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (adv) begin
      out_result <= (s2_mode == 2'b00) ? s2_p[DATA_W-1:0] : hi_fix;
      out_tag    <= s2_tag;
    end
  end

endmodule

// File: tb/tb_nios2_mul_pipe.sv
// tb_nios2_mul_pipe: directed and randomised checks of the pipelined multiplier
// against a 2*DATA_W signed/unsigned arithmetic reference.
module tb_nios2_mul_pipe;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_src1;
  logic [W-1:0]  in_src2;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  nios2_mul_pipe #(.DATA_W(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0]   m);
    logic signed [2*W-1:0] x, y, p;
    x = m[1] ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    y = (m == 2'b11) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p = x * y;
    return (m == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [1:0] m,
                       input logic [TW-1:0] t);
    in_valid = v;
    in_src1  = a;
    in_src2  = b;
    in_mode  = m;
    in_tag   = t;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, '1, '1, 2'b01, 5'd3);
    repeat (3) next_cycle();
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
        out_result !== '0 || out_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b result=%h tag=%h, want 0 0 0 0",
               out_valid, in_ready, out_result, out_tag);
    end
    next_cycle();
    reset_n = 1'b1;
    drive(1'b0, '0, '0, 2'b00, '0);
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b valid=%b, want 1 0",
               in_ready, out_valid);
    end
    next_cycle();
  endtask

  task automatic test_all_ones();
    logic [W-1:0] want [4];
    logic         ev;
    int           idx;
    want[0] = 32'h0000_0001;
    want[1] = 32'hFFFF_FFFE;
    want[2] = 32'hFFFF_FFFF;
    want[3] = 32'h0000_0000;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, '1, '1, 2'(c), 5'(c));
      else drive(1'b0, '0, '0, 2'b00, '0);
      @(negedge clk);
      ev  = (c >= 3 && c < 7);
      idx = (c >= 3) ? c - 3 : 0;
      if (c < 4) begin
        n_chk++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ones_in_ready c=%0d: got %b want 1", c, in_ready);
        end
      end
      n_chk++;
      if (out_valid !== ev ||
          (ev && (out_result !== want[idx] || out_tag !== 5'(idx)))) begin
        n_fail++;
        $display("FAIL ones_out c=%0d: valid=%b result=%h tag=%0d, want %b %h %0d",
                 c, out_valid, out_result, out_tag, ev, want[idx], idx);
      end
      next_cycle();
    end
  endtask

  task automatic test_products();
    logic [W-1:0] a [3];
    logic [W-1:0] b [3];
    logic [1:0]   m [3];
    logic [W-1:0] want [3];
    logic         ev;
    int           idx;
    a[0] = 32'h8000_0000; b[0] = 32'h8000_0000; m[0] = 2'b11; want[0] = 32'h4000_0000;
    a[1] = 32'h0001_2345; b[1] = 32'h0000_1000; m[1] = 2'b00; want[1] = 32'h1234_5000;
    a[2] = 32'h8000_0000; b[2] = 32'h0000_0002; m[2] = 2'b10; want[2] = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) drive(1'b1, a[c], b[c], m[c], 5'(10 + c));
      else drive(1'b0, '0, '0, 2'b00, '0);
      @(negedge clk);
      ev  = (c >= 3 && c < 6);
      idx = (c >= 3 && c < 6) ? c - 3 : 0;
      n_chk++;
      if (out_valid !== ev ||
          (ev && (out_result !== want[idx] || out_tag !== 5'(10 + idx)))) begin
        n_fail++;
        $display("FAIL products c=%0d: valid=%b result=%h tag=%0d, want %b %h %0d",
                 c, out_valid, out_result, out_tag, ev, want[idx], 10 + idx);
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a [4];
    logic [W-1:0] b [4];
    logic [1:0]   m [4];
    int sent = 0;
    int got  = 0;
    for (int i = 0; i < 4; i++) begin
      a[i] = pick();
      b[i] = pick();
      m[i] = 2'($urandom_range(0, 3));
    end
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c < 8);
      if (sent < 4) drive(1'b1, a[sent], b[sent], m[sent], 5'(20 + sent));
      else drive(1'b0, '0, '0, 2'b00, '0);
      @(negedge clk);
      if (c >= 4 && c < 8) begin
        n_chk++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
            out_result !== ref_mul(a[0], b[0], m[0]) || out_tag !== 5'd20) begin
          n_fail++;
          $display("FAIL stall_hold c=%0d: valid=%b ready=%b result=%h tag=%0d, want 1 0 %h 20",
                   c, out_valid, in_ready, out_result, out_tag,
                   ref_mul(a[0], b[0], m[0]));
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_chk++;
        if (got >= 4) begin
          n_fail++;
          $display("FAIL bp_extra c=%0d: result=%h tag=%0d, want none",
                   c, out_result, out_tag);
        end else if (out_result !== ref_mul(a[got], b[got], m[got]) ||
                     out_tag !== 5'(20 + got)) begin
          n_fail++;
          $display("FAIL bp_order %0d: result=%h tag=%0d, want %h %0d", got,
                   out_result, out_tag, ref_mul(a[got], b[got], m[got]), 20 + got);
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      next_cycle();
    end
    n_chk++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, want 4", got);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_flush();
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = 32'hDEAD_BEEF;
    y = 32'h1234_5678;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      flush = (c == 3);
      if (c < 3) drive(1'b1, W'($urandom), W'($urandom), 2'(c), 5'(c));
      else if (c == 3) drive(1'b1, x, y, 2'b11, 5'd9);
      else if (c == 7) drive(1'b1, x, y, 2'b10, 5'd17);
      else drive(1'b0, '0, '0, 2'b00, '0);
      @(negedge clk);
      if (c == 3) begin
        n_chk++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_ready: got %b want 0", in_ready);
        end
      end
      if (c >= 4 && c < 10) begin
        n_chk++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_kill c=%0d: valid=%b want 0", c, out_valid);
        end
      end
      if (c == 10) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_result !== ref_mul(x, y, 2'b10) ||
            out_tag !== 5'd17) begin
          n_fail++;
          $display("FAIL flush_after: valid=%b result=%h tag=%0d, want 1 %h 17",
                   out_valid, out_result, out_tag, ref_mul(x, y, 2'b10));
        end
      end
      next_cycle();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      reset_n = (c != 3);
      if (c < 3) drive(1'b1, pick(), pick(), 2'(c + 1), 5'(c));
      else drive(1'b0, '0, '0, 2'b00, '0);
      @(negedge clk);
      if (c == 3) begin
        n_chk++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_mid_ready: got %b want 0", in_ready);
        end
      end
      if (c >= 4) begin
        n_chk++;
        if (out_valid !== 1'b0 || (c == 4 && in_ready !== 1'b1)) begin
          n_fail++;
          $display("FAIL rst_mid c=%0d: valid=%b ready=%b, want 0 1",
                   c, out_valid, in_ready);
        end
      end
      next_cycle();
    end
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    exp_t         q [$];
    exp_t         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   m;
    logic [TW-1:0] t;
    logic         tail;
    logic         want_ready;
    for (int c = 0; c < 20010; c++) begin
      tail = (c >= 20000);
      a = pick();
      b = pick();
      m = 2'($urandom_range(0, 3));
      t = TW'($urandom);
      drive(!tail && ($urandom_range(0, 9) < 7), a, b, m, t);
      out_ready = tail || ($urandom_range(0, 9) < 7);
      flush     = !tail && ($urandom_range(0, 49) == 0);
      @(negedge clk);
      want_ready = (!out_valid || out_ready) && !flush;
      n_chk++;
      if (in_ready !== want_ready || (out_valid === 1'b1 && q.size() == 0)) begin
        n_fail++;
        $display("FAIL rnd_ctrl c=%0d: ready=%b valid=%b pending=%0d, want ready %b",
                 c, in_ready, out_valid, q.size(), want_ready);
      end
      if (out_valid === 1'b1 && out_ready && !flush && q.size() != 0) begin
        e = q.pop_front();
        n_chk++;
        if (out_result !== e.res || out_tag !== e.tag) begin
          n_fail++;
          $display("FAIL rnd_result c=%0d: result=%h tag=%0d, want %h %0d",
                   c, out_result, out_tag, e.res, e.tag);
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready === 1'b1) begin
        e.res = ref_mul(a, b, m);
        e.tag = t;
        q.push_back(e);
      end
      n_chk++;
      if (q.size() > 3) begin
        n_fail++;
        $display("FAIL rnd_depth c=%0d: %0d in flight, want <= 3", c, q.size());
      end
      next_cycle();
    end
    n_chk++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_drain: %0d undelivered, valid=%b, want 0 0",
               q.size(), out_valid);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'b00, '0);
    test_reset();
    test_all_ones();
    test_products();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
